stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl.sv | 179 +++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch front end: input sync, button debounce, tick divider, mode FSM
module stopwatch_ctrl #(
    parameter int CLK_HZ = 100000000,
    parameter int DB_CYC = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_pause_raw,
    input  logic       btn_clr_raw,
    input  logic       btn_inc_raw,
    input  logic       btn_dec_raw,
    input  logic       sw_adj,
    input  logic       sw_sel,
    input  logic       sw_adj_b,
    input  logic       sw_cnt_dn,
    output logic       tick_1hz,
    output logic       tick_2hz,
    output logic       pause_p,
    output logic       clr_p,
    output logic       inc_p,
    output logic       dec_p,
    output logic       adj,
    output logic       sel,
    output logic       adj_b,
    output logic       cnt_dn,
    output logic [1:0] mode
);

    localparam int HALF  = CLK_HZ / 2;
    localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int DB_W  = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYC - 1);

    localparam int B_PAUSE  = 0;
    localparam int B_CLR    = 1;
    localparam int B_INC    = 2;
    localparam int B_DEC    = 3;
    localparam int S_ADJ    = 4;
    localparam int S_SEL    = 5;
    localparam int S_ADJ_B  = 6;
    localparam int S_CNT_DN = 7;

    typedef enum logic [1:0] {
        RUN_UP   = 2'b00,
        RUN_DN   = 2'b01,
        ADJ_MAN  = 2'b10,
        ADJ_AUTO = 2'b11
    } state_t;

    logic [7:0]            raw;
    logic [7:0]            sync1_q, sync1_d;
    logic [7:0]            sync2_q, sync2_d;
    logic [3:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [3:0]            db_q, db_d;
    logic [3:0]            db_dly_q, db_dly_d;
    logic [3:0]            rise;
    logic [DIV_W-1:0]      div_q, div_d;
    logic                  phase_q, phase_d;
    logic                  div_wrap;
    logic                  mode_change;
    state_t                state_q, state_d;
    logic                  pause_p_q, pause_p_d;
    logic                  clr_p_q, clr_p_d;
    logic                  inc_p_q, inc_p_d;
    logic                  dec_p_q, dec_p_d;

    assign raw = {sw_cnt_dn, sw_adj_b, sw_sel, sw_adj,
                  btn_dec_raw, btn_inc_raw, btn_clr_raw, btn_pause_raw};

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
    end

    // A level flips only after DB_CYC consecutive samples disagree with it.
    always_comb begin
        db_cnt_d = db_cnt_q;
        db_d     = db_q;
        db_dly_d = db_q;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] == db_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                db_cnt_d[i] = '0;
                db_d[i]     = ~db_q[i];
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
        end
    end

    assign rise = db_q & ~db_dly_q;

    // Next state follows the switch values about to appear on adj/adj_b/cnt_dn,
    // so mode always agrees with the synchronized switch outputs.
    always_comb begin
        state_d = RUN_UP;
        if (sync1_q[S_ADJ]) begin
            state_d = sync1_q[S_ADJ_B] ? ADJ_MAN : ADJ_AUTO;
        end else begin
            state_d = sync1_q[S_CNT_DN] ? RUN_DN : RUN_UP;
        end
        mode_change = (state_d != state_q);
    end

    always_comb begin
        div_wrap = (div_q == DIV_LAST);
        div_d    = div_q + DIV_W'(1);
        phase_d  = phase_q;
        if (mode_change) begin
            div_d   = '0;
            phase_d = 1'b0;
        end else if (div_wrap) begin
            div_d   = '0;
            phase_d = ~phase_q;
        end
    end

    always_comb begin
        pause_p_d = 1'b0;
        clr_p_d   = rise[B_CLR];
        inc_p_d   = 1'b0;
        dec_p_d   = 1'b0;
        case (state_q)
            RUN_UP, RUN_DN: pause_p_d = rise[B_PAUSE] & ~rise[B_CLR];
            ADJ_MAN: begin
                inc_p_d = rise[B_INC] & ~rise[B_DEC];
                dec_p_d = rise[B_DEC] & ~rise[B_INC];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_cnt_q  <= '0;
            db_q      <= '0;
            db_dly_q  <= '0;
            div_q     <= '0;
            phase_q   <= 1'b0;
            state_q   <= RUN_UP;
            pause_p_q <= 1'b0;
            clr_p_q   <= 1'b0;
            inc_p_q   <= 1'b0;
            dec_p_q   <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_cnt_q  <= db_cnt_d;
            db_q      <= db_d;
            db_dly_q  <= db_dly_d;
            div_q     <= div_d;
            phase_q   <= phase_d;
            state_q   <= state_d;
            pause_p_q <= pause_p_d;
            clr_p_q   <= clr_p_d;
            inc_p_q   <= inc_p_d;
            dec_p_q   <= dec_p_d;
        end
    end

    assign tick_2hz = div_wrap & ~mode_change & (state_q == ADJ_AUTO);
    assign tick_1hz = div_wrap & phase_q & ~mode_change &
                      ((state_q == RUN_UP) || (state_q == RUN_DN));

    assign pause_p = pause_p_q;
    assign clr_p   = clr_p_q;
    assign inc_p   = inc_p_q;
    assign dec_p   = dec_p_q;
    assign adj     = sync2_q[S_ADJ];
    assign sel     = sync2_q[S_SEL];
    assign adj_b   = sync2_q[S_ADJ_B];
    assign cnt_dn  = sync2_q[S_CNT_DN];
    assign mode    = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed and random checks of stopwatch_ctrl against a behavioural model
module tb_stopwatch_ctrl;

    localparam int CLK_HZ = 8;
    localparam int DB_CYC = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_pause_raw, btn_clr_raw, btn_inc_raw, btn_dec_raw;
    logic       sw_adj, sw_sel, sw_adj_b, sw_cnt_dn;
    logic       tick_1hz, tick_2hz;
    logic       pause_p, clr_p, inc_p, dec_p;
    logic       adj, sel, adj_b, cnt_dn;
    logic [1:0] mode;

    stopwatch_ctrl #(.CLK_HZ(CLK_HZ), .DB_CYC(DB_CYC)) dut (
        .clk(clk), .rst(rst),
        .btn_pause_raw(btn_pause_raw), .btn_clr_raw(btn_clr_raw),
        .btn_inc_raw(btn_inc_raw), .btn_dec_raw(btn_dec_raw),
        .sw_adj(sw_adj), .sw_sel(sw_sel), .sw_adj_b(sw_adj_b), .sw_cnt_dn(sw_cnt_dn),
        .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
        .pause_p(pause_p), .clr_p(clr_p), .inc_p(inc_p), .dec_p(dec_p),
        .adj(adj), .sel(sel), .adj_b(adj_b), .cnt_dn(cnt_dn), .mode(mode)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n     = 0;
    int base;
    int c0, c1;
    int rise_n;
    int t1_last_n;
    int cnt_t1 = 0;
    int cnt_t2 = 0;
    int cnt_p [4];
    int p_last_n [4];
    bit [7:0] cur;

    // Model: raw bit order 0 pause,1 clr,2 inc,3 dec,4 adj,5 sel,6 adj_b,7 cnt_dn
    bit [7:0] praw_m, syn_m;
    bit [3:0] lvl_m, rose_m, p_m;
    int       run_m [4];
    int       mode_m, k_m;

    function automatic int mode_of(input bit [7:0] s);
        if (s[4]) return s[6] ? 2 : 3;
        return s[7] ? 1 : 0;
    endfunction

    task automatic model_reset();
        praw_m = '0; syn_m = '0; lvl_m = '0; rose_m = '0; p_m = '0;
        for (int b = 0; b < 4; b++) run_m[b] = 0;
        mode_m = 0; k_m = 0;
    endtask

    task automatic model_edge(input bit [7:0] r);
        bit [3:0] nr;
        int nm;
        p_m[0] = rose_m[0] && !rose_m[1] && (mode_m < 2);
        p_m[1] = rose_m[1];
        p_m[2] = rose_m[2] && !rose_m[3] && (mode_m == 2);
        p_m[3] = rose_m[3] && !rose_m[2] && (mode_m == 2);
        nr = '0;
        for (int b = 0; b < 4; b++) begin
            if (syn_m[b] != lvl_m[b]) begin
                run_m[b]++;
                if (run_m[b] == DB_CYC) begin
                    lvl_m[b] = ~lvl_m[b];
                    run_m[b] = 0;
                    nr[b] = lvl_m[b];
                end
            end else begin
                run_m[b] = 0;
            end
        end
        rose_m = nr;
        syn_m  = praw_m;
        praw_m = r;
        nm = mode_of(syn_m);
        k_m = (nm != mode_m) ? 0 : k_m + 1;
        mode_m = nm;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, n);
        end
    endtask

    task automatic check_all();
        bit pend;
        pend = (mode_of(praw_m) != mode_m);
        chk("tick_1hz", {31'd0, tick_1hz}, {31'd0, (mode_m < 2) && (k_m % 8 == 7) && !pend});
        chk("tick_2hz", {31'd0, tick_2hz}, {31'd0, (mode_m == 3) && (k_m % 4 == 3) && !pend});
        chk("pause_p", {31'd0, pause_p}, {31'd0, p_m[0]});
        chk("clr_p", {31'd0, clr_p}, {31'd0, p_m[1]});
        chk("inc_p", {31'd0, inc_p}, {31'd0, p_m[2]});
        chk("dec_p", {31'd0, dec_p}, {31'd0, p_m[3]});
        chk("adj", {31'd0, adj}, {31'd0, syn_m[4]});
        chk("sel", {31'd0, sel}, {31'd0, syn_m[5]});
        chk("adj_b", {31'd0, adj_b}, {31'd0, syn_m[6]});
        chk("cnt_dn", {31'd0, cnt_dn}, {31'd0, syn_m[7]});
        chk("mode", {30'd0, mode}, mode_m);
        if (tick_1hz === 1'b1) begin cnt_t1++; t1_last_n = n; end
        if (tick_2hz === 1'b1) cnt_t2++;
        if (pause_p === 1'b1) begin cnt_p[0]++; p_last_n[0] = n; end
        if (clr_p === 1'b1) begin cnt_p[1]++; p_last_n[1] = n; end
        if (inc_p === 1'b1) begin cnt_p[2]++; p_last_n[2] = n; end
        if (dec_p === 1'b1) begin cnt_p[3]++; p_last_n[3] = n; end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_outs"}, {20'd0, tick_1hz, tick_2hz, pause_p, clr_p, inc_p, dec_p,
                             adj, sel, adj_b, cnt_dn, mode}, 32'd0);
    endtask

    task automatic drive(input bit [7:0] r);
        btn_pause_raw = r[0]; btn_clr_raw = r[1]; btn_inc_raw = r[2]; btn_dec_raw = r[3];
        sw_adj = r[4]; sw_sel = r[5]; sw_adj_b = r[6]; sw_cnt_dn = r[7];
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cyc(input bit [7:0] r);
        drive(r);
        @(posedge clk);
        model_edge(r);
        #1;
        n++;
        check_all();
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1 chk_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1 chk_zero("rst_held");
        @(negedge clk);
        rst = 1'b0;
        base = n;
    endtask

    initial begin
        for (int b = 0; b < 4; b++) begin cnt_p[b] = 0; p_last_n[b] = -1; end
        t1_last_n = -1;
        cur = '0;
        rst = 1'b1;
        drive(8'h00);
        model_reset();
        repeat (2) @(posedge clk);
        #1 chk_zero("por");
        @(negedge clk);
        rst = 1'b0;
        base = n;

        // Free-running RUN_UP: tick_1hz every 8 cycles, first at cycle 7
        c0 = cnt_t1; c1 = cnt_t2;
        repeat (8) cyc(8'h00);
        chk("s1_first_t1", t1_last_n - base, 7);
        repeat (16) cyc(8'h00);
        chk("s1_t1_count", cnt_t1 - c0, 3);
        chk("s1_t2_count", cnt_t2 - c1, 0);

        // Bouncing pause press
        c0 = cnt_p[0];
        cyc(8'h01); cyc(8'h00); cyc(8'h01);
        rise_n = n;
        repeat (9) cyc(8'h01);
        repeat (8) cyc(8'h00);
        chk("s2_pause_count", cnt_p[0] - c0, 1);
        chk("s2_pause_lat", p_last_n[0] - (rise_n - 1), 3 + DB_CYC);

        // clr and pause together: clr wins
        c0 = cnt_p[0]; c1 = cnt_p[1];
        repeat (8) cyc(8'h03);
        repeat (8) cyc(8'h00);
        chk("s3_clr_count", cnt_p[1] - c1, 1);
        chk("s3_pause_count", cnt_p[0] - c0, 0);

        // ADJ_AUTO: 2 Hz ticks only, pause dropped
        c0 = cnt_t1; c1 = cnt_t2;
        cyc(8'h10);
        cyc(8'h10);
        chk("s4_mode", {30'd0, mode}, 3);
        repeat (16) cyc(8'h10);
        chk("s4_t2_count", cnt_t2 - c1, 4);
        chk("s4_t1_count", cnt_t1 - c0, 0);
        c0 = cnt_p[0];
        repeat (8) cyc(8'h11);
        repeat (6) cyc(8'h10);
        chk("s4_pause_drop", cnt_p[0] - c0, 0);

        // ADJ_MAN: simultaneous inc/dec cancel, single presses pass
        repeat (4) cyc(8'h50);
        chk("s5_mode", {30'd0, mode}, 2);
        c0 = cnt_p[2]; c1 = cnt_p[3];
        repeat (8) cyc(8'h5C);
        repeat (8) cyc(8'h50);
        chk("s5_both_inc", cnt_p[2] - c0, 0);
        chk("s5_both_dec", cnt_p[3] - c1, 0);
        repeat (8) cyc(8'h54);
        repeat (8) cyc(8'h50);
        chk("s5_inc_alone", cnt_p[2] - c0, 1);
        repeat (8) cyc(8'h58);
        repeat (8) cyc(8'h50);
        chk("s5_dec_alone", cnt_p[3] - c1, 1);

        // Reset mid-count with pause held through it
        repeat (17) cyc(8'h00);
        cyc(8'h01); cyc(8'h01);
        do_reset();
        t1_last_n = -1;
        c0 = cnt_p[0];
        repeat (12) cyc(8'h01);
        chk("s6_pause_count", cnt_p[0] - c0, 1);
        chk("s6_pause_lat", p_last_n[0] - base, DB_CYC + 3);
        chk("s6_first_t1", t1_last_n - base, 7);
        repeat (8) cyc(8'h00);

        // Random bouncing buttons, slow switches, occasional reset
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 3) == 0) cur[b] = ~cur[b];
            for (int b = 4; b < 8; b++) if ($urandom_range(0, 39) == 0) cur[b] = ~cur[b];
            if ($urandom_range(0, 599) == 0) do_reset();
            cyc(cur);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
